// File: rtl/ram_wc_fifo.sv
// Width-converting lane FIFO: writes 1..LANES lanes per cycle, reads one registered lane per cycle.
// Read latency 1 cycle; over-full writes and empty reads are dropped and flagged on o_err.
module ram_wc_fifo #(
  parameter int D_WIDTH = 128,
  parameter int LANES   = 4,
  parameter int A_WIDTH = 4,
  parameter int NL_W    = $clog2(LANES) + 1
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_en_w,
  input  logic [NL_W-1:0]          i_nlanes,
  input  logic [LANES*D_WIDTH-1:0] i_data,
  input  logic                     i_en_r,
  input  logic                     i_clr,
  output logic [D_WIDTH-1:0]       o_data,
  output logic                     o_sig,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [A_WIDTH:0]         o_level,
  output logic                     o_err
);

  localparam int DEPTH = 1 << A_WIDTH;
  localparam int LW    = A_WIDTH + 1;

  logic [A_WIDTH-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0]      level_q, level_d;
  logic [D_WIDTH-1:0] data_q, data_d;
  logic               sig_q, sig_d, err_q, err_d;
  logic [D_WIDTH-1:0] mem_q [DEPTH];
  logic [D_WIDTH-1:0] mem_d [DEPTH];

  logic [LW-1:0] nl_ext, free;
  logic          nl_valid, wr_ok, rd_ok;

  // Acceptance uses the pre-edge level only, so a same-cycle read never frees room for a write.
  always_comb begin
    nl_ext   = LW'(i_nlanes);
    free     = LW'(DEPTH) - level_q;
    nl_valid = (i_nlanes != '0) && (i_nlanes <= NL_W'(LANES));
    wr_ok    = i_en_w && nl_valid && (free >= nl_ext);
    rd_ok    = i_en_r && (level_q != '0);
  end

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    data_d  = data_q;
    sig_d   = 1'b0;
    err_d   = 1'b0;
    if (i_clr) begin
      wp_d    = '0;
      rp_d    = '0;
      level_d = '0;
      data_d  = '0;
    end else begin
      sig_d = rd_ok;
      err_d = (i_en_w && !wr_ok) || (i_en_r && !rd_ok);
      if (rd_ok) begin
        data_d = mem_q[rp_q];
        rp_d   = rp_q + A_WIDTH'(1);
      end
      if (wr_ok) begin
        wp_d = wp_q + A_WIDTH'(i_nlanes);
      end
      level_d = level_q + (wr_ok ? nl_ext : '0) - LW'(rd_ok);
    end
  end

  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < LANES; k++) begin
      if (wr_ok && (k < int'(i_nlanes))) begin
        mem_d[wp_q + A_WIDTH'(k)] = i_data[k*D_WIDTH +: D_WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      data_q  <= '0;
      sig_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      data_q  <= data_d;
      sig_q   <= sig_d;
      err_q   <= err_d;
    end
  end

  assign o_data  = data_q;
  assign o_sig   = sig_q;
  assign o_err   = err_q;
  assign o_level = level_q;
  assign o_empty = (level_q == '0);
  assign o_full  = (LW'(DEPTH) - level_q) < LW'(LANES);

endmodule
